time_set_ctrl: RTL

Time-setting controller for the digital clock: the write side of the h/m/s counter. It takes the three debounced push-buttons (config, increment, decrement) and walks the user through editing hours, minutes and seconds. It then loads the edited time back into the counter and drives per-field blanking to the 8-digit display path so the field being edited blinks. It sits between the debounce instances and the counter/display driver, on clk_100MHz_i.

---
 rtl/time_set_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Write side of the h/m/s counter in the digital clock. Three debounced
// buttons let the user step through hours, minutes and seconds and change
// each one. The edited time is then loaded back into the counter with a
// one-cycle strobe. While a field is being edited, its display digits blink.
// If no button is pressed for TIMEOUT_S seconds, edit mode is abandoned
// without a load.
//
// Parameters
//   BLINK_HALF  clk cycles per blink half-period
//   TIMEOUT_S   seconds_pulse_i ticks without a press before edit aborts
//
// Ports
//   clk_100MHz_i      system clock
//   reset_i           asynchronous, active-low reset
//   seconds_pulse_i   one-cycle 1 Hz tick
//   config_i          debounced button level: next field / commit
//   increment_i       debounced button level: field + 1
//   decrement_i       debounced button level: field - 1
//   hours_i           live hours from the counter (5 bits)
//   minutes_i         live minutes from the counter (6 bits)
//   seconds_i         live seconds from the counter (6 bits)
//   hours_o           edited hours (5 bits)
//   minutes_o         edited minutes (6 bits)
//   seconds_o         edited seconds (6 bits)
//   load_o            one-cycle strobe; counter takes hours_o/minutes_o/seconds_o
//   run_en_o          counter may advance; low while editing
//   mode_o            00 RUN, 01 SET_H, 10 SET_M, 11 SET_S
//   blank_o           [2] hours, [1] minutes, [0] seconds; 1 blanks the field
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int BLINK_HALF = 50_000_000,
    parameter int TIMEOUT_S  = 30
) (
    input  logic       clk_100MHz_i,
    input  logic       reset_i,
    input  logic       seconds_pulse_i,
    input  logic       config_i,
    input  logic       increment_i,
    input  logic       decrement_i,
    input  logic [4:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    output logic [4:0] hours_o,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic       load_o,
    output logic       run_en_o,
    output logic [1:0] mode_o,
    output logic [2:0] blank_o
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } state_t;

    state_t          state, state_d;
    logic [4:0]      hours_q, hours_d;
    logic [5:0]      minutes_q, minutes_d;
    logic [5:0]      seconds_q, seconds_d;
    logic            load_q, load_d;
    logic [TW-1:0]   tmo_cnt, tmo_d;
    logic [BW-1:0]   blink_cnt, blink_d;
    logic            phase, phase_d;
    logic            prev_cfg, prev_inc, prev_dec;

    logic cfg_p, inc_p, dec_p, any_p, step_up, step_dn;

    // Rising edge = level high while last cycle's level was low.
    assign cfg_p   = config_i    & ~prev_cfg;
    assign inc_p   = increment_i & ~prev_inc;
    assign dec_p   = decrement_i & ~prev_dec;
    assign any_p   = cfg_p | inc_p | dec_p;
    // Inc and dec together cancel out.
    assign step_up = inc_p & ~dec_p;
    assign step_dn = dec_p & ~inc_p;

    // Wrapping +1/-1 on a field whose range is 0..max.
    function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] max,
                                        input logic up, input logic dn);
        logic [5:0] r;
        r = v;
        if (up)      r = (v == max)  ? 6'd0 : v + 6'd1;
        else if (dn) r = (v == 6'd0) ? max  : v - 6'd1;
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        load_d    = 1'b0;
        tmo_d     = tmo_cnt;
        if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_d = '0;
            phase_d = ~phase;
        end else begin
            blink_d = blink_cnt + BW'(1);
            phase_d = phase;
        end

        if (state == RUN) begin
            tmo_d = '0;
            if (cfg_p) begin
                // Capture the live time. Values that are out of range start from 0.
                state_d   = SET_H;
                hours_d   = (hours_i   > 5'd23) ? 5'd0 : hours_i;
                minutes_d = (minutes_i > 6'd59) ? 6'd0 : minutes_i;
                seconds_d = (seconds_i > 6'd59) ? 6'd0 : seconds_i;
                blink_d   = '0;
                phase_d   = 1'b0;
            end
        end else if (cfg_p) begin
            // Config takes priority over a coincident inc/dec press.
            tmo_d   = '0;
            blink_d = '0;
            phase_d = 1'b0;
            case (state)
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: begin
                    state_d = RUN;
                    load_d  = 1'b1;
                end
            endcase
        end else begin
            // A press beats a tick in the same cycle.
            if (any_p) begin
                tmo_d = '0;
            end else if (seconds_pulse_i) begin
                if (tmo_cnt == TW'(TIMEOUT_S - 1)) begin
                    state_d = RUN;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_cnt + TW'(1);
                end
            end
            // Restart the blink so the edited value is shown immediately.
            if (inc_p | dec_p) begin
                blink_d = '0;
                phase_d = 1'b0;
            end
            case (state)
                SET_H:   hours_d   = 5'(bump({1'b0, hours_q}, 6'd23, step_up, step_dn));
                SET_M:   minutes_d = bump(minutes_q, 6'd59, step_up, step_dn);
                default: seconds_d = bump(seconds_q, 6'd59, step_up, step_dn);
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
        if (!reset_i) begin
            // NOTE: every register, counters included, has a defined reset
            // value. The prev regs reset high so a button held through reset
            // does not register as a press.
            state     <= RUN;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            load_q    <= 1'b0;
            tmo_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            prev_cfg  <= 1'b1;
            prev_inc  <= 1'b1;
            prev_dec  <= 1'b1;
        end else begin
            state     <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            load_q    <= load_d;
            tmo_cnt   <= tmo_d;
            blink_cnt <= blink_d;
            phase     <= phase_d;
            prev_cfg  <= config_i;
            prev_inc  <= increment_i;
            prev_dec  <= decrement_i;
        end
    end

    // Outputs are decoded only from registers.
    assign hours_o   = hours_q;
    assign minutes_o = minutes_q;
    assign seconds_o = seconds_q;
    assign load_o    = load_q;
    assign mode_o    = state;
    assign run_en_o  = (state == RUN);

    always_comb begin
        blank_o = 3'b000;
        case (state)
            SET_H:   blank_o[2] = phase;
            SET_M:   blank_o[1] = phase;
            SET_S:   blank_o[0] = phase;
            default: blank_o    = 3'b000;
        endcase
    end

endmodule
